snpu_rnd_harvester: RTL

// Reader side of the SNPU random-bank interface. Drives the bank's freeze and

---
 rtl/snpu_rnd_harvester.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/snpu_rnd_harvester.sv
// snpu_rnd_harvester
// Reader for the SNPU random banks. Scans the banks round-robin, freezes each
// one long enough for its output mux to settle, captures the 16-bit word,
// von Neumann debiases it pair by pair and packs surviving bits into bytes on
// a valid/ready stream. A repetition test on captured words latches a sticky
// health failure and parks the reader.
module snpu_rnd_harvester #(
    parameter int N_BANKS   = 32,
    parameter int ADDR_W    = 5,
    parameter int WORD_W    = 16,
    parameter int SETTLE    = 3,
    parameter int REP_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              freeze,
    output logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] rnd_word,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              health_fail
);

    localparam int PAIRS  = WORD_W / 2;
    localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_HOLD,
        S_CAPTURE,
        S_DEBIAS,
        S_FAIL
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SET_W-1:0]    settle_cnt;
    logic [PAIR_W-1:0]   pair_idx;
    logic [WORD_W-1:0]   word;
    logic [WORD_W-1:0]   last_word;
    logic [REP_W-1:0]    rep_cnt;
    logic [7:0]          acc;
    logic [2:0]          bit_cnt;

    logic [1:0]          pair;
    logic                keep;
    logic                bit_val;
    logic                slot_free;
    logic                byte_done;
    logic                stall;
    logic                last_pair;
    logic [REP_W-1:0]    rep_next;
    logic                rep_trip;
    logic [ADDR_W-1:0]   addr_inc;

    // Debias decode, byte-slot availability and repetition-test lookahead
    always_comb begin
        pair      = word[{pair_idx, 1'b0} +: 2];
        keep      = pair[1] ^ pair[0];
        bit_val   = pair[1];
        slot_free = !out_valid || out_ready;
        // The eighth kept bit goes straight into out_data, so a full byte
        // never sits in acc; if the slot is busy the pair is simply retried.
        byte_done = keep && (bit_cnt == 3'd7);
        stall     = (state == S_DEBIAS) && byte_done && !slot_free;
        last_pair = (pair_idx == PAIR_W'(PAIRS - 1));
        rep_next  = (rnd_word == last_word) ? rep_cnt + 1'b1 : REP_W'(1);
        rep_trip  = (rep_next >= REP_W'(REP_LIMIT));
        addr_inc  = (addr == ADDR_W'(N_BANKS - 1)) ? '0 : addr + 1'b1;
    end

    // Next-state selection for the scan sequence
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (en) state_next = S_ARM;
            S_ARM:     state_next = S_HOLD;
            S_HOLD:    if (settle_cnt == SET_W'(SETTLE - 1)) state_next = S_CAPTURE;
            S_CAPTURE: state_next = rep_trip ? S_FAIL : S_DEBIAS;
            S_DEBIAS:  if (!stall && last_pair) state_next = en ? S_ARM : S_IDLE;
            S_FAIL:    state_next = S_FAIL;
            default:   state_next = S_IDLE;
        endcase
    end

    // State register, settle counter and registered freeze (high in HOLD and CAPTURE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            freeze     <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= (state == S_HOLD) ? settle_cnt + 1'b1 : '0;
            freeze     <= (state_next == S_HOLD) || (state_next == S_CAPTURE);
        end
    end

    // Word capture, repetition test, sticky health flag and bank advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word        <= '0;
            last_word   <= '0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
            addr        <= '0;
        end else if (state == S_CAPTURE) begin
            word      <= rnd_word;
            last_word <= rnd_word;
            rep_cnt   <= rep_next;
            if (rep_trip) begin
                health_fail <= 1'b1;
            end else begin
                addr <= addr_inc;
            end
        end
    end

    // Pair walk and bit accumulation; a stalled pair leaves everything untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_idx <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
        end else if (state == S_CAPTURE) begin
            pair_idx <= '0;
        end else if ((state == S_DEBIAS) && !stall) begin
            pair_idx <= last_pair ? '0 : pair_idx + 1'b1;
            if (keep) begin
                acc     <= {acc[6:0], bit_val};
                bit_cnt <= byte_done ? 3'd0 : bit_cnt + 1'b1;
            end
        end
    end

    // Output slot: load a completed byte, otherwise retire an accepted one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if ((state == S_DEBIAS) && byte_done && slot_free) begin
            out_data  <= {acc[6:0], bit_val};
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
